// File: rtl/rx_packet_control_if.sv
// Line/timer-side strobes into the RX packet controller and its
// status outputs to the bit timer and RX FIFO.
interface rx_packet_control_if;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic [6:0] byte_cnt;

  modport master (
    output d_edge, eop, shift_enable,
    output byte_received, rcv_data,
    input  rcving, w_enable,
    input  r_error, byte_cnt
  );

  modport slave (
    input  d_edge, eop, shift_enable,
    input  byte_received, rcv_data,
    output rcving, w_enable,
    output r_error, byte_cnt
  );
endinterface

// File: rtl/rx_packet_control.sv
// RX packet control FSM: sync check, byte store strobes,
// end-of-packet and error tracking.
module rx_packet_control #(
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int         MAX_BYTES    = 64
) (
  input logic clk,
  input logic rst,
  rx_packet_control_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    SYNC,
    CHECK,
    RECV,
    STORE,
    EOP_WAIT,
    ERR,
    ERR_EOP,
    ERR_IDLE
  } state_t;

  localparam logic [6:0] LP_MAX = 7'(MAX_BYTES);

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_byte_cnt;
  logic       r_err_flag;
  logic       w_room;
  logic       w_eop_bit;

  assign w_room    = r_byte_cnt < LP_MAX;
  assign w_eop_bit = bus.eop & bus.shift_enable;

  // Outputs depend only on registered state, never on inputs
  assign bus.rcving   = (r_state == SYNC)  ||
                        (r_state == CHECK) ||
                        (r_state == RECV)  ||
                        (r_state == STORE);
  assign bus.w_enable = (r_state == STORE) && w_room;
  assign bus.r_error  = r_err_flag;
  assign bus.byte_cnt = r_byte_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_err_flag <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.d_edge) begin
            r_state    <= SYNC;
            r_err_flag <= 1'b0;
            r_byte_cnt <= '0;
          end
        end
        SYNC: begin
          if (bus.byte_received) begin
            r_state <= CHECK;
          end else if (w_eop_bit) begin
            r_state    <= ERR;
            r_err_flag <= 1'b1;
          end
        end
        CHECK: begin
          if (bus.rcv_data == SYNC_PATTERN) begin
            r_state   <= RECV;
            r_bit_cnt <= '0;
          end else begin
            r_state    <= ERR;
            r_err_flag <= 1'b1;
          end
        end
        RECV: begin
          if (bus.byte_received) begin
            r_state   <= STORE;
            r_bit_cnt <= '0;
          end else if (w_eop_bit) begin
            if (r_bit_cnt == 3'd0) begin
              r_state <= EOP_WAIT;
            end else begin
              r_state    <= ERR;
              r_err_flag <= 1'b1;
            end
          end else if (bus.shift_enable) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        STORE: begin
          if (w_room) begin
            r_state    <= RECV;
            r_byte_cnt <= r_byte_cnt + 7'd1;
          end else begin
            r_state    <= ERR;
            r_err_flag <= 1'b1;
          end
        end
        EOP_WAIT: begin
          if (bus.d_edge) r_state <= IDLE;
        end
        ERR: begin
          if (bus.eop) r_state <= ERR_EOP;
        end
        ERR_EOP: begin
          if (bus.d_edge) r_state <= ERR_IDLE;
        end
        ERR_IDLE: begin
          if (bus.d_edge) begin
            r_state    <= SYNC;
            r_err_flag <= 1'b0;
            r_byte_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
